// File: rtl/lane_fifo4_8bits.sv
// lane_fifo4_8bits
//
// Receive-side buffer sitting behind the 2-to-4 lane demux (clk_f domain).
// Four independent 8-bit FIFOs, one per lane, each with its own push
// (valid_rxN) and pop (popN) handshake, a registered read port with
// one-clock latency, and per-lane status flags derived from the count.
//
// Ports:
//   clk_f                  lane clock, all state updates on rising edge
//   reset                  asynchronous active-high reset
//   data_rx0..3  [7:0]     write data per lane
//   valid_rx0..3           push request per lane
//   pop0..3                read request per lane
//   data_out0..3 [7:0]     registered read data (holds when no pop)
//   valid_out0..3          data_outN carries a word popped on the last edge
//   full/empty         [3:0]  per-lane count==DEPTH / count==0
//   almost_full        [3:0]  per-lane count>=AFULL
//   almost_empty       [3:0]  per-lane count<=AEMPTY
//   err_overflow       [3:0]  sticky, set when a push is dropped on that lane
//   err_count          [7:0]  saturating total of dropped pushes
//
// Build option:
//   LANE_FIFO_ERRCNT_EN  when defined, err_count counts dropped pushes
//                        (all lanes summed, saturating at 8'hFF); otherwise
//                        err_count is tied to 8'h00 and no counter exists.

module lane_fifo4_8bits #(
    parameter int DEPTH  = 8,
    parameter int AFULL  = 6,
    parameter int AEMPTY = 2
) (
    input  logic       clk_f,
    input  logic       reset,
    input  logic [7:0] data_rx0,
    input  logic [7:0] data_rx1,
    input  logic [7:0] data_rx2,
    input  logic [7:0] data_rx3,
    input  logic       valid_rx0,
    input  logic       valid_rx1,
    input  logic       valid_rx2,
    input  logic       valid_rx3,
    input  logic       pop0,
    input  logic       pop1,
    input  logic       pop2,
    input  logic       pop3,
    output logic [7:0] data_out0,
    output logic [7:0] data_out1,
    output logic [7:0] data_out2,
    output logic [7:0] data_out3,
    output logic       valid_out0,
    output logic       valid_out1,
    output logic       valid_out2,
    output logic       valid_out3,
    output logic [3:0] full,
    output logic [3:0] empty,
    output logic [3:0] almost_full,
    output logic [3:0] almost_empty,
    output logic [3:0] err_overflow,
    output logic [7:0] err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AFULL  = CW'(AFULL);
    localparam logic [CW-1:0] CNT_AEMPTY = CW'(AEMPTY);

    logic [3:0][7:0] din;
    logic [3:0]      push_req;
    logic [3:0]      pop_req;

    assign din      = {data_rx3, data_rx2, data_rx1, data_rx0};
    assign push_req = {valid_rx3, valid_rx2, valid_rx1, valid_rx0};
    assign pop_req  = {pop3, pop2, pop1, pop0};

    // Storage is deliberately not reset; the pointers/count define validity.
    logic [7:0]    mem_q [4][DEPTH];

    logic [AW-1:0] wr_ptr_q [4];
    logic [AW-1:0] wr_ptr_d [4];
    logic [AW-1:0] rd_ptr_q [4];
    logic [AW-1:0] rd_ptr_d [4];
    logic [CW-1:0] cnt_q    [4];
    logic [CW-1:0] cnt_d    [4];
    logic [7:0]    dout_q   [4];
    logic [7:0]    dout_d   [4];
    logic [3:0]    vout_q;
    logic [3:0]    vout_d;
    logic [3:0]    ovf_q;
    logic [3:0]    ovf_d;

    logic [3:0]    push_ok;
    logic [3:0]    pop_ok;
    logic [3:0]    drop;

    // Per-lane handshake resolution. A full lane still accepts a push when
    // the same edge pops, so the slot being read is reused. An empty lane
    // never pops, even with a concurrent push (no fall-through path).
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            pop_ok[l]   = pop_req[l] && (cnt_q[l] != '0);
            push_ok[l]  = push_req[l] && ((cnt_q[l] != CNT_FULL) || pop_ok[l]);
            drop[l]     = push_req[l] && !push_ok[l];

            wr_ptr_d[l] = push_ok[l] ? wr_ptr_q[l] + AW'(1) : wr_ptr_q[l];
            rd_ptr_d[l] = pop_ok[l]  ? rd_ptr_q[l] + AW'(1) : rd_ptr_q[l];
            cnt_d[l]    = cnt_q[l] + CW'(push_ok[l]) - CW'(pop_ok[l]);

            vout_d[l]   = pop_ok[l];
            dout_d[l]   = pop_ok[l] ? mem_q[l][rd_ptr_q[l]] : dout_q[l];
        end
        ovf_d = ovf_q | drop;
    end

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            for (int l = 0; l < 4; l++) begin
                wr_ptr_q[l] <= '0;
                rd_ptr_q[l] <= '0;
                cnt_q[l]    <= '0;
                dout_q[l]   <= 8'h00;
            end
            vout_q <= '0;
            ovf_q  <= '0;
        end else begin
            for (int l = 0; l < 4; l++) begin
                wr_ptr_q[l] <= wr_ptr_d[l];
                rd_ptr_q[l] <= rd_ptr_d[l];
                cnt_q[l]    <= cnt_d[l];
                dout_q[l]   <= dout_d[l];
            end
            vout_q <= vout_d;
            ovf_q  <= ovf_d;
        end
    end

    // On a simultaneous push/pop to a full lane wr_ptr == rd_ptr; the read
    // above samples the old word before this write lands.
    always_ff @(posedge clk_f) begin
        for (int l = 0; l < 4; l++) begin
            if (push_ok[l]) begin
                mem_q[l][wr_ptr_q[l]] <= din[l];
            end
        end
    end

    always_comb begin
        for (int l = 0; l < 4; l++) begin
            full[l]         = (cnt_q[l] == CNT_FULL);
            empty[l]        = (cnt_q[l] == '0);
            almost_full[l]  = (cnt_q[l] >= CNT_AFULL);
            almost_empty[l] = (cnt_q[l] <= CNT_AEMPTY);
        end
    end

    assign err_overflow = ovf_q;

    assign data_out0  = dout_q[0];
    assign data_out1  = dout_q[1];
    assign data_out2  = dout_q[2];
    assign data_out3  = dout_q[3];
    assign valid_out0 = vout_q[0];
    assign valid_out1 = vout_q[1];
    assign valid_out2 = vout_q[2];
    assign valid_out3 = vout_q[3];

`ifdef LANE_FIFO_ERRCNT_EN
    logic [7:0] errcnt_q;
    logic [7:0] errcnt_d;
    logic [2:0] drop_num;
    logic [8:0] errcnt_sum;

    // Up to four drops per edge; a 9-bit sum exposes the carry for saturation.
    always_comb begin
        drop_num   = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
        errcnt_sum = {1'b0, errcnt_q} + 9'(drop_num);
        errcnt_d   = errcnt_sum[8] ? 8'hFF : errcnt_sum[7:0];
    end

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            errcnt_q <= 8'h00;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign err_count = errcnt_q;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_lane_fifo4_8bits.sv
module tb_lane_fifo4_8bits;

    localparam int DEPTH  = 8;
    localparam int AFULL  = 6;
    localparam int AEMPTY = 2;

    logic       clk_f = 1'b0;
    logic       reset;
    logic [7:0] din  [4];
    logic [3:0] vin;
    logic [3:0] pin;
    logic [7:0] dout [4];
    logic [3:0] vout;
    logic [3:0] full, empty, almost_full, almost_empty, err_overflow;
    logic [7:0] err_count;

    always #5 clk_f = ~clk_f;

    lane_fifo4_8bits #(.DEPTH(DEPTH), .AFULL(AFULL), .AEMPTY(AEMPTY)) dut (
        .clk_f        (clk_f),
        .reset        (reset),
        .data_rx0     (din[0]),
        .data_rx1     (din[1]),
        .data_rx2     (din[2]),
        .data_rx3     (din[3]),
        .valid_rx0    (vin[0]),
        .valid_rx1    (vin[1]),
        .valid_rx2    (vin[2]),
        .valid_rx3    (vin[3]),
        .pop0         (pin[0]),
        .pop1         (pin[1]),
        .pop2         (pin[2]),
        .pop3         (pin[3]),
        .data_out0    (dout[0]),
        .data_out1    (dout[1]),
        .data_out2    (dout[2]),
        .data_out3    (dout[3]),
        .valid_out0   (vout[0]),
        .valid_out1   (vout[1]),
        .valid_out2   (vout[2]),
        .valid_out3   (vout[3]),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .err_overflow (err_overflow),
        .err_count    (err_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one queue per lane plus the observable registers.
    logic [7:0] mq [4][$];
    logic [7:0] m_dout [4];
    logic [3:0] m_vout;
    logic [3:0] m_ovf;
    int         m_err;

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       p0;
        logic       e_full;
        logic       e_af;
        logic       e_empty;
        logic       e_vout;
        logic [7:0] e_dout;
    } vec_t;

    vec_t tbl [16];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < 4; l++) begin
            mq[l].delete();
            m_dout[l] = 8'h00;
        end
        m_vout = '0;
        m_ovf  = '0;
        m_err  = 0;
    endtask

    task automatic model_step();
        int drops;
        bit pok;
        drops = 0;
        for (int l = 0; l < 4; l++) begin
            pok = pin[l] && (mq[l].size() > 0);
            m_vout[l] = pok;
            if (pok) m_dout[l] = mq[l].pop_front();
            if (vin[l]) begin
                if (mq[l].size() < DEPTH) begin
                    mq[l].push_back(din[l]);
                end else begin
                    m_ovf[l] = 1'b1;
                    drops++;
                end
            end
        end
`ifdef LANE_FIFO_ERRCNT_EN
        m_err = (m_err + drops > 255) ? 255 : m_err + drops;
`endif
    endtask

    task automatic check_model(input string tag);
        logic [3:0] ef, ee, eaf, eae;
        for (int l = 0; l < 4; l++) begin
            ef[l]  = (mq[l].size() == DEPTH);
            ee[l]  = (mq[l].size() == 0);
            eaf[l] = (mq[l].size() >= AFULL);
            eae[l] = (mq[l].size() <= AEMPTY);
        end
        cmp({tag, ".full"}, full, ef);
        cmp({tag, ".empty"}, empty, ee);
        cmp({tag, ".almost_full"}, almost_full, eaf);
        cmp({tag, ".almost_empty"}, almost_empty, eae);
        cmp({tag, ".err_overflow"}, err_overflow, m_ovf);
        cmp({tag, ".err_count"}, err_count, m_err);
        cmp({tag, ".valid_out"}, vout, m_vout);
        for (int l = 0; l < 4; l++)
            cmp($sformatf("%s.data_out%0d", tag, l), dout[l], m_dout[l]);
    endtask

    task automatic step(input string tag);
        @(posedge clk_f);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic idle();
        vin = '0;
        pin = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 8'hBC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[4]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[5]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[6]  = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hBC};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h04};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h06};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07};

        for (int l = 0; l < 4; l++) din[l] = 8'h00;
        idle();
        reset = 1'b1;
        model_reset();
        #12;
        cmp("reset.empty", empty, 4'b1111);
        cmp("reset.full", full, 4'b0000);
        cmp("reset.almost_empty", almost_empty, 4'b1111);
        cmp("reset.almost_full", almost_full, 4'b0000);
        cmp("reset.valid_out", vout, 4'b0000);
        cmp("reset.err_overflow", err_overflow, 4'b0000);
        cmp("reset.err_count", err_count, 8'h00);
        for (int l = 0; l < 4; l++) cmp($sformatf("reset.data_out%0d", l), dout[l], 8'h00);
        @(negedge clk_f);
        reset = 1'b0;
        step("idle");

        // Lane 0 fill/drain from the vector table.
        for (int i = 0; i < 16; i++) begin
            vin[0] = tbl[i].v0;
            din[0] = tbl[i].d0;
            pin[0] = tbl[i].p0;
            step("lane0_tbl");
            cmp($sformatf("lane0_tbl[%0d].full0", i), full[0], tbl[i].e_full);
            cmp($sformatf("lane0_tbl[%0d].afull0", i), almost_full[0], tbl[i].e_af);
            cmp($sformatf("lane0_tbl[%0d].empty0", i), empty[0], tbl[i].e_empty);
            cmp($sformatf("lane0_tbl[%0d].vout0", i), vout[0], tbl[i].e_vout);
            cmp($sformatf("lane0_tbl[%0d].dout0", i), dout[0], tbl[i].e_dout);
        end
        idle();

        // Lane 2: fill, push+pop at full, then overflow.
        for (int i = 0; i < 8; i++) begin
            vin[2] = 1'b1;
            din[2] = 8'h20 + 8'(i);
            step("lane2_fill");
        end
        pin[2] = 1'b1;
        din[2] = 8'hAA;
        step("lane2_full_pushpop");
        cmp("lane2_full_pushpop.vout2", vout[2], 1'b1);
        cmp("lane2_full_pushpop.dout2", dout[2], 8'h20);
        cmp("lane2_full_pushpop.full2", full[2], 1'b1);
        pin[2] = 1'b0;
        din[2] = 8'h55;
        step("lane2_overflow");
        cmp("lane2_overflow.ovf2", err_overflow[2], 1'b1);
        cmp("lane2_overflow.ovf_others", {err_overflow[3], err_overflow[1:0]}, 3'b000);
        cmp("lane2_overflow.full2", full[2], 1'b1);
        vin[2] = 1'b0;
        pin[2] = 1'b1;
        for (int i = 0; i < 8; i++) step("lane2_drain");
        cmp("lane2_drain.last_is_AA", dout[2], 8'hAA);
        cmp("lane2_drain.empty2", empty[2], 1'b1);
        idle();

        // Lane 1: push and pop together while empty.
        vin[1] = 1'b1;
        din[1] = 8'h3C;
        pin[1] = 1'b1;
        step("lane1_empty_pushpop");
        cmp("lane1_empty_pushpop.vout1", vout[1], 1'b0);
        cmp("lane1_empty_pushpop.empty1", empty[1], 1'b0);
        vin[1] = 1'b0;
        step("lane1_pop");
        cmp("lane1_pop.vout1", vout[1], 1'b1);
        cmp("lane1_pop.dout1", dout[1], 8'h3C);
        idle();
        step("lane1_after");
        cmp("lane1_after.vout1", vout[1], 1'b0);

        // Lane 3: pointer wrap at steady count 3.
        for (int i = 0; i < 3; i++) begin
            vin[3] = 1'b1;
            din[3] = 8'(i);
            step("lane3_prefill");
        end
        pin[3] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din[3] = 8'(i + 3);
            step("lane3_wrap");
            cmp($sformatf("lane3_wrap[%0d].dout3", i), dout[3], 8'(i));
            cmp($sformatf("lane3_wrap[%0d].vout3", i), vout[3], 1'b1);
        end
        idle();

        // Randomized traffic: push-heavy then pop-heavy.
        for (int c = 0; c < 400; c++) begin
            for (int l = 0; l < 4; l++) begin
                vin[l] = ($urandom_range(0, 99) < ((c < 200) ? 70 : 30));
                pin[l] = ($urandom_range(0, 99) < ((c < 200) ? 30 : 70));
                din[l] = 8'($urandom);
            end
            step("random");
        end
        idle();

        // All lanes full, then sustained pushes to drive err_count.
        vin = 4'b1111;
        for (int c = 0; c < 78; c++) begin
            for (int l = 0; l < 4; l++) din[l] = 8'($urandom);
            step("overflow_all");
        end
        cmp("overflow_all.full", full, 4'b1111);
        cmp("overflow_all.ovf", err_overflow, 4'b1111);
`ifdef LANE_FIFO_ERRCNT_EN
        cmp("overflow_all.err_count_sat", err_count, 8'hFF);
`else
        cmp("overflow_all.err_count_tied", err_count, 8'h00);
`endif

        // Asynchronous reset mid-stream.
        @(posedge clk_f);
        model_step();
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        cmp("async_reset.err_count", err_count, 8'h00);
        cmp("async_reset.empty", empty, 4'b1111);
        cmp("async_reset.full", full, 4'b0000);
        cmp("async_reset.ovf", err_overflow, 4'b0000);
        check_model("async_reset");
        @(negedge clk_f);
        reset = 1'b0;
        idle();
        vin[0] = 1'b1;
        din[0] = 8'h77;
        step("post_reset_push");
        vin[0] = 1'b0;
        pin[0] = 1'b1;
        step("post_reset_pop");
        cmp("post_reset_pop.dout0", dout[0], 8'h77);
        idle();
        step("end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lane_fifo4_8bits.md
Name: lane_fifo4_8bits

Overview:
- Receive-side buffer directly downstream of the 2-to-4 lane demux, in the clk_f domain.
- Holds four independent 8-bit FIFOs, one per lane, written from the demux lane outputs (data_rx0..3 / valid_rx0..3).
- Each lane is read by the consumer through its own pop handshake.
- Reports per-lane full, empty, almost-full and almost-empty status, plus sticky overflow errors.

Parameters:
- DEPTH, 8, entries per lane FIFO; power of two, minimum 4.
- AFULL, 6, almost_full asserts when lane count >= AFULL; range 1..DEPTH.
- AEMPTY, 2, almost_empty asserts when lane count <= AEMPTY; range 0..DEPTH-1.

Ports:
- clk_f  in  1  lane clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- data_rx0, data_rx1, data_rx2, data_rx3  in  8 each  write data per lane.
- valid_rx0, valid_rx1, valid_rx2, valid_rx3  in  1 each  push request per lane.
- pop0, pop1, pop2, pop3  in  1 each  read request per lane.
- data_out0, data_out1, data_out2, data_out3  out  8 each  registered read data.
- valid_out0, valid_out1, valid_out2, valid_out3  out  1 each  data_outN holds a popped word this cycle.
- full  out  4  bit N = lane N full.
- empty  out  4  bit N = lane N empty.
- almost_full  out  4  bit N = lane N count >= AFULL.
- almost_empty  out  4  bit N = lane N count <= AEMPTY.
- err_overflow  out  4  bit N sticky, set when a push is dropped on lane N.
- err_count  out  8  saturating count of dropped pushes, summed over all lanes (see Optional Feature).

Behaviour:
- Reset, asynchronous, active-high, clears:
  - all write/read pointers and counts to 0;
  - data_out* = 8'h00, valid_out* = 0;
  - full = 4'b0000, empty = 4'b1111, err_overflow = 4'b0000, err_count = 0;
  - almost_full and almost_empty take the values derived from count = 0.
  - RAM contents are not cleared.
  - Reset asserted mid-operation discards all buffered data; the first push after deassertion goes to entry 0.
- Lanes are fully independent. Per lane, per rising edge:
  - Push: valid_rxN=1 and lane not full -> the word is written at wr_ptr; wr_ptr increments modulo DEPTH.
  - Pop: popN=1 and lane not empty -> the word at rd_ptr is registered into data_outN with valid_outN=1; rd_ptr increments modulo DEPTH. Read latency is 1 clock.
  - If there is no successful pop: valid_outN=0 and data_outN holds its previous value.
  - Pop on empty is ignored. No underflow flag; valid_outN stays 0.
  - Push on full drops the word, sets err_overflow[N], and leaves count unchanged.
  - Push and pop together, lane full: both succeed; count stays DEPTH; full stays 1.
  - Push and pop together, lane empty: pop ignored (no fall-through bypass); push accepted; count becomes 1.
  - Push and pop together, otherwise: both succeed; count unchanged.
- Count is clog2(DEPTH)+1 bits wide and ranges 0..DEPTH.
- Status outputs are combinational from the registered count:
  - full = (count==DEPTH); empty = (count==0); almost_full = (count>=AFULL); almost_empty = (count<=AEMPTY).
  - Status therefore reflects an edge's push/pop immediately after that edge.
- Pointer wrap is by natural modulo DEPTH. Full and empty are distinguished by the count, not by pointer equality.

Optional Feature:
- Macro: LANE_FIFO_ERRCNT_EN.
- Defined: err_count increments by the number of lanes that drop a push in that cycle (0..4), saturating at 8'hFF. Cleared only by reset.
- Not defined: err_count is tied to 8'h00 and no counter logic is built. err_overflow is unaffected either way.

Test Plan:
- Reset release, no traffic -> empty=4'b1111, full=0, almost_empty=4'b1111, all valid_out=0, data_out=8'h00.
- Lane 0: push 8'hBC, 8'h01..8'h07 on consecutive clocks (8 words), then pop 8 clocks -> full[0]=1 after the 8th push; almost_full[0]=1 from the 6th push; pops return BC,01..07 in order, each one clock after its pop; empty[0]=1 at the end.
- Lane 2 full: push 8'hAA with pop2=1 -> count stays 8, oldest word out, AA stored. Then push 8'h55 without pop -> word dropped, err_overflow[2]=1, other lanes unaffected.
- Lane 1 empty: assert pop1 and push 8'h3C in the same cycle -> valid_out1=0 that cycle, count=1; the next pop returns 3C.
- Wrap: lane 3 runs 20 push/pop pairs with values 0..19 at steady count 3 -> output stream is 0..19 in order with no loss.
- LANE_FIFO_ERRCNT_EN defined: all four lanes full, 70 cycles of pushes on all lanes -> err_count saturates at 8'hFF. Then assert reset mid-stream -> err_count=0 and empty=4'b1111 asynchronously.
